// File: rtl/blueintegral_mm_link_pkg.sv
// Shared types and constants for the 2x2 binary matrix-multiply pin link.
package blueintegral_mm_link_pkg;

  localparam int OP_W       = 8;  // packed operand word A00..A11,B00..B11
  localparam int RES_ELEM_W = 2;  // one result element, value 0..2
  localparam int RES_ELEMS  = 4;  // C00, C01, C10, C11

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CALC = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Select result element idx from the packed result, C00 (MSBs) first.
  function automatic logic [RES_ELEM_W-1:0] res_elem(input logic [OP_W-1:0] res,
                                                    input logic [1:0]      idx);
    logic [RES_ELEM_W-1:0] elem;
    case (idx)
      2'd0:    elem = res[7:6];
      2'd1:    elem = res[5:4];
      2'd2:    elem = res[3:2];
      2'd3:    elem = res[1:0];
      default: elem = res[7:6];
    endcase
    return elem;
  endfunction

endpackage

// File: rtl/blueintegral_mm_link_if.sv
// Bus bundle between the link block, its pin-side producer/consumer and the multiplier.
interface blueintegral_mm_link_if #(parameter int DIN_W = 2);
  import blueintegral_mm_link_pkg::*;

  logic [DIN_W-1:0]      din;
  logic                  din_valid;
  logic                  in_ready;
  logic [RES_ELEM_W-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  busy;
  logic [OP_W-1:0]       mm_in;
  logic [OP_W-1:0]       mm_out;

  // Link block side.
  modport slave (
    input  din, din_valid, dout_ready, mm_out,
    output in_ready, dout, dout_valid, busy, mm_in
  );

  // Environment side (pin producer/consumer and multiplier).
  modport master (
    output din, din_valid, dout_ready, mm_out,
    input  in_ready, dout, dout_valid, busy, mm_in
  );
endinterface

// File: rtl/blueintegral_mm_link.sv
// Operand loader / result serializer for the 2x2 binary matrix multiplier.
// Shifts in an 8-bit operand word DIN_W bits at a time, hands it to the
// combinational multiplier for one cycle, then streams the four 2-bit results.
module blueintegral_mm_link
  import blueintegral_mm_link_pkg::*;
#(
  parameter int DIN_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  blueintegral_mm_link_if.slave   link
);

  localparam int         IN_BEATS = OP_W / DIN_W;
  localparam logic [2:0] LAST_IN  = 3'(IN_BEATS - 1);
  localparam logic [1:0] LAST_OUT = 2'(RES_ELEMS - 1);

  state_e          state_q, state_d;
  logic [2:0]      in_cnt_q, in_cnt_d;
  logic [1:0]      out_cnt_q, out_cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [OP_W-1:0] res_q, res_d;

  // State register: synchronous reset discards any partial transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      in_cnt_q  <= 3'd0;
      out_cnt_q <= 2'd0;
      op_q      <= {OP_W{1'b0}};
      res_q     <= {OP_W{1'b0}};
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      op_q      <= op_d;
      res_q     <= res_d;
    end
  end

  // Next-state logic: shift in operands, capture result, count out elements.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    op_d      = op_q;
    res_d     = res_q;
    case (state_q)
      ST_LOAD: begin
        if (link.din_valid) begin
          op_d = {op_q[OP_W-1-DIN_W:0], link.din};
          if (in_cnt_q == LAST_IN) begin
            in_cnt_d = 3'd0;
            state_d  = ST_CALC;
          end else begin
            in_cnt_d = in_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CALC: begin
        res_d     = link.mm_out;
        out_cnt_d = 2'd0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (link.dout_ready) begin
          out_cnt_d = out_cnt_q + 2'd1;
          if (out_cnt_q == LAST_OUT) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Output decode: every output is a function of registered state only,
  // except in_ready which is also gated off while reset is held.
  always_comb begin
    link.in_ready   = (state_q == ST_LOAD) && !reset;
    link.dout_valid = (state_q == ST_SEND);
    link.dout       = res_elem(res_q, out_cnt_q);
    link.busy       = (state_q != ST_LOAD) || (in_cnt_q != 3'd0);
    link.mm_in      = op_q;
  end

endmodule

// File: tb/tb_blueintegral_mm_link.sv
// Directed bench for blueintegral_mm_link at DIN_W = 2, 1 and 4.
module tb_blueintegral_mm_link;

  logic clk = 1'b0;
  logic reset;
  logic dout_rdy;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   sel   = 0;
  int   n_cyc;

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  blueintegral_mm_link_if #(.DIN_W(2)) if2();
  blueintegral_mm_link_if #(.DIN_W(1)) if1();
  blueintegral_mm_link_if #(.DIN_W(4)) if4();

  blueintegral_mm_link #(.DIN_W(2)) dut2 (.clk(clk), .reset(reset), .link(if2.slave));
  blueintegral_mm_link #(.DIN_W(1)) dut1 (.clk(clk), .reset(reset), .link(if1.slave));
  blueintegral_mm_link #(.DIN_W(4)) dut4 (.clk(clk), .reset(reset), .link(if4.slave));

  // Behavioural 2x2 binary matrix multiply: C = A * B, integer sums.
  function automatic logic [7:0] mm_model(input logic [7:0] x);
    logic [1:0] c00, c01, c10, c11;
    c00 = {1'b0, x[7] & x[3]} + {1'b0, x[6] & x[1]};
    c01 = {1'b0, x[7] & x[2]} + {1'b0, x[6] & x[0]};
    c10 = {1'b0, x[5] & x[3]} + {1'b0, x[4] & x[1]};
    c11 = {1'b0, x[5] & x[2]} + {1'b0, x[4] & x[0]};
    return {c00, c01, c10, c11};
  endfunction

  assign if2.mm_out = mm_model(if2.mm_in);
  assign if1.mm_out = mm_model(if1.mm_in);
  assign if4.mm_out = mm_model(if4.mm_in);
  assign if2.dout_ready = dout_rdy;
  assign if1.dout_ready = dout_rdy;
  assign if4.dout_ready = dout_rdy;

  logic [1:0] o_dout;
  logic       o_valid, o_inrdy, o_busy;
  logic [7:0] o_mm;

  // Observe the instance currently under test.
  always_comb begin
    case (sel)
      1: begin o_dout = if1.dout; o_valid = if1.dout_valid; o_inrdy = if1.in_ready; o_busy = if1.busy; o_mm = if1.mm_in; end
      2: begin o_dout = if4.dout; o_valid = if4.dout_valid; o_inrdy = if4.in_ready; o_busy = if4.busy; o_mm = if4.mm_in; end
      default: begin o_dout = if2.dout; o_valid = if2.dout_valid; o_inrdy = if2.in_ready; o_busy = if2.busy; o_mm = if2.mm_in; end
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load one word into the DIN_W=2 instance; gap idle cycles before each beat.
  task automatic load2(input logic [7:0] w, input int gap);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        if2.din_valid = 1'b0;
        @(negedge clk);
        chk("gap_in_ready", {7'd0, o_inrdy}, 8'd1);
        @(posedge clk); #1;
      end
      if2.din = w[7-2*i -: 2];
      if2.din_valid = 1'b1;
      @(posedge clk); #1;
    end
    if2.din_valid = 1'b0;
    n_cyc = cyc;
  endtask

  // Receive four elements (dout_ready high), starting at a negedge.
  task automatic recv(input logic [7:0] res, input string tag);
    int w;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!o_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk({tag, "_valid"}, {7'd0, o_valid}, 8'd1);
      chk({tag, "_dout"}, {6'd0, o_dout}, {6'd0, res[7-2*k -: 2]});
      chk({tag, "_no_in_ready"}, {7'd0, o_inrdy}, 8'd0);
      @(negedge clk);
    end
    chk({tag, "_end_valid"}, {7'd0, o_valid}, 8'd0);
    chk({tag, "_end_in_ready"}, {7'd0, o_inrdy}, 8'd1);
    chk({tag, "_end_busy"}, {7'd0, o_busy}, 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    dout_rdy = 1'b1;
    if2.din = 2'd0; if2.din_valid = 1'b0;
    if1.din = 1'd0; if1.din_valid = 1'b0;
    if4.din = 4'd0; if4.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {7'd0, o_inrdy}, 8'd0);
    chk("rst_busy", {7'd0, o_busy}, 8'd0);
    chk("rst_dout_valid", {7'd0, o_valid}, 8'd0);
    chk("rst_dout", {6'd0, o_dout}, 8'd0);
    chk("rst_mm_in", o_mm, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {7'd0, o_inrdy}, 8'd1);

    // All-ones word, strict latency check.
    load2(8'hFF, 0);
    @(negedge clk);
    chk("calc_in_ready", {7'd0, o_inrdy}, 8'd0);
    chk("calc_valid", {7'd0, o_valid}, 8'd0);
    chk("calc_busy", {7'd0, o_busy}, 8'd1);
    chk("calc_mm_in", o_mm, 8'hFF);
    @(negedge clk);
    chk("lat_first_valid", {7'd0, o_valid}, 8'd1);
    recv(8'hAA, "ones");
    chk("lat_last_consume", 8'(cyc - n_cyc), 8'd5);

    // Identity times swap.
    load2(8'h96, 0);
    @(negedge clk);
    recv(8'h14, "swap");

    // Stall on first output beat.
    load2(8'hCA, 0);
    dout_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", {7'd0, o_valid}, 8'd1);
      chk("stall_dout", {6'd0, o_dout}, 8'd2);
      @(negedge clk);
    end
    dout_rdy = 1'b1;
    recv(8'h80, "stall");
    chk("mm_in_held", o_mm, 8'hCA);

    // Input gaps.
    load2(8'h96, 3);
    @(negedge clk);
    recv(8'h14, "gaps");

    // Reset mid-load, then a clean word.
    @(posedge clk); #1;
    if2.din = 2'b01; if2.din_valid = 1'b1;
    @(posedge clk); #1;
    if2.din = 2'b10;
    @(posedge clk); #1;
    if2.din_valid = 1'b0;
    @(negedge clk);
    chk("partial_busy", {7'd0, o_busy}, 8'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {7'd0, o_inrdy}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {7'd0, o_busy}, 8'd0);
    chk("midrst_mm_in", o_mm, 8'h00);
    load2(8'hFF, 0);
    @(negedge clk);
    chk("midrst_word", o_mm, 8'hFF);
    recv(8'hAA, "midrst");

    // DIN_W = 1: bits 1,0,0,1,0,1,1,0.
    sel = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if1.din = 1'((8'h96 >> (7 - i)) & 8'h01);
      if1.din_valid = 1'b1;
      @(posedge clk); #1;
    end
    if1.din_valid = 1'b0;
    @(negedge clk);
    chk("w1_mm_in", o_mm, 8'h96);
    recv(8'h14, "w1");

    // DIN_W = 4: beats 0x9, 0x6.
    sel = 2;
    @(posedge clk); #1;
    if4.din = 4'h9; if4.din_valid = 1'b1;
    @(posedge clk); #1;
    if4.din = 4'h6;
    @(posedge clk); #1;
    if4.din_valid = 1'b0;
    @(negedge clk);
    chk("w4_mm_in", o_mm, 8'h96);
    recv(8'h14, "w4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
